float_mul_stream: RTL
=====================

Name: float_mul_stream

Overview:
- Fully pipelined IEEE-754-style floating-point multiplier with configurable exponent and mantissa widths.
- Accepts one operation per clock over a valid/ready stream with backpressure, and carries a user tag alongside each operation.
- Successor to the single-outstanding req/ack multiplier: several operations in flight, explicit special-value handling, round-to-nearest-even.
- Sits between the shader ALU issue stage and the writeback arbiter.

Parameters:
- exp_width, 8, exponent field bits.
- mant_width, 23, stored fraction bits. Derived: float_width = 1 + exp_width + mant_width; bias = 2^(exp_width-1) - 1.
- tag_width, 4, width of the opaque tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair is valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- in_a  in  float_width  operand A.
- in_b  in  float_width  operand B.
- in_tag  in  tag_width  tag returned with the result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  float_width  A*B.
- out_tag  out  tag_width  tag of the operation in out_result.

Behaviour:
- Reset: when rst=1 at an edge, all stage valid bits clear, out_valid=0, out_result=0, out_tag=0. Operations in flight are discarded. in_ready is 1 in the first cycle after reset.
- Transfer rule: a transfer occurs on a valid&ready edge.
- in_ready = ~(out_valid & ~out_ready). A single global stall holds every stage when the output is held.
- out_valid, out_result and out_tag stay stable while stalled.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Order is strictly FIFO; tags are never reordered.
- S1 (unpack/classify):
  - Sign = sa^sb.
  - Class per operand: zero (exp=0, including subnormals, which are flushed), inf, NaN, normal.
  - Exponent sum = ea+eb-bias, held as a signed value exp_width+2 bits wide.
- S2 (multiply):
  - (1.ma)*(1.mb) gives an unsigned product 2*(mant_width+1) bits wide.
- S3 (normalise/round/pack):
  - If the product MSB is set, shift right 1 and exponent +1.
  - Round to nearest even using guard bit plus sticky (OR of the remaining bits).
  - If rounding carries out of the mantissa, renormalise and exponent +1.
- Special cases, in priority order:
  1. Any NaN input, or inf*zero → canonical qNaN: sign 0, exp all ones, fraction MSB 1, rest 0.
  2. Inf*(inf or normal) → signed infinity.
  3. Any zero → signed zero (sign = sa^sb).
  4. Final biased exponent ≥ 2^exp_width-1 → signed infinity (overflow).
  5. Final biased exponent ≤ 0 → signed zero (underflow; no subnormal output).
- Simultaneous events:
  - Input and output transfer in the same cycle are both legal; the pipeline advances.
  - in_valid while in_ready=0: inputs are ignored, and the source must hold them.

Optional Feature:
- Macro: FLOAT_MUL_STATUS_EN.
- When defined: an extra output port out_flags [3:0] = {invalid, overflow, underflow, inexact}.
  - It is registered with out_result, follows the same stall rules, and resets to 0.
  - invalid is set for the qNaN case 1.
  - inexact is set when guard|sticky=1, or when overflow or underflow occurred.
- When not defined: the port and flag logic are absent; everything else is unchanged.

Decomposition:
- Package float_mul_pkg contains:
  - the derived localparam functions (float_width, bias);
  - the class enum {FC_ZERO, FC_NORM, FC_INF, FC_NAN};
  - the S1→S2 and S2→S3 stage structs (valid, tag, sign, classes, exponent, mantissas/product);
  - the flag index constants.
- One sub-module: float_classify, a combinational unpack of a single operand into sign, exponent, implicit-1 mantissa and class. It is instantiated twice in S1.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release → out_valid=0, in_ready=1. Send 0x3F800000*0x3F800000 (1.0*1.0) with tag 3 → 0x3F800000 and tag 3 exactly 3 cycles later.
- Back-to-back, out_ready=1: 0x40000000*0x40133333 (2.0*2.3), then 0xC4FA0000*0x40133333 (-2000*2.3), then 0x42C80000*0x40900000 (100*4.5), on consecutive cycles → 0x40933333, 0xC58FC000, 0x43E10000 on consecutive cycles, in order.
- Specials:
  - 0x00000000*0x7F800000 (0*inf) → 0x7FC00000; with FLOAT_MUL_STATUS_EN, flags = 4'b1000.
  - 0x80000000*0x3F800000 (-0*1.0) → 0x80000000.
  - 0x7FC00001*0x3F800000 (NaN*1.0) → 0x7FC00000.
- Range: 0x7149F2CA*0x7149F2CA (1e30*1e30) → 0x7F800000; 0x0DA24260*0x0DA24260 (1e-30*1e-30) → 0x00000000.
- Backpressure: stream 6 ops with out_ready=0 for cycles 4-7.
  - in_ready drops while out_valid=1 and out_ready=0.
  - out_result and out_tag stay stable during the stall.
  - All 6 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst with 3 ops in flight → out_valid=0 on the next cycle and none of the 3 results ever appear. A new op after release completes with 3-cycle latency.

Source files
------------

// File: rtl/float_mul_pkg.sv
// Shared definitions for the streaming floating-point multiplier:
// format-width helpers, operand class encoding and status-flag bit positions.
package float_mul_pkg;

    // Total encoded width of a float with the given field widths.
    function automatic int float_width(input int exp_width, input int mant_width);
        return 1 + exp_width + mant_width;
    endfunction

    // Exponent bias for the given exponent field width.
    function automatic int bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Operand classification; subnormals are folded into FC_ZERO.
    typedef enum logic [1:0] {
        FC_ZERO,
        FC_NORM,
        FC_INF,
        FC_NAN
    } fclass_e;

    // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int NUM_FLAGS      = 4;

endpackage

// File: rtl/float_mul_stream_classify.sv
// Combinational unpack of one operand: sign, biased exponent,
// significand with the implicit leading one, and operand class.
module float_classify
    import float_mul_pkg::*;
#(
    parameter int exp_width  = 8,
    parameter int mant_width = 23
) (
    input  logic [exp_width+mant_width:0] op,
    output logic                          sign,
    output logic [exp_width-1:0]          biased_exp,
    output logic [mant_width:0]           mant,
    output fclass_e                       cls
);

    // Split the fields and classify; a zero exponent flushes subnormals to zero.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        sign       = op[exp_width+mant_width];
        biased_exp = op[exp_width+mant_width-1 -: exp_width];
        mant       = {1'b1, op[mant_width-1:0]};
        cls        = FC_NORM;
        if (op[exp_width+mant_width-1 -: exp_width] == '0) begin
            cls = FC_ZERO;
        end else if (&op[exp_width+mant_width-1 -: exp_width]) begin
            cls = (op[mant_width-1:0] == '0) ? FC_INF : FC_NAN;
        end
    end

endmodule

// File: rtl/float_mul_stream.sv
// Three-stage pipelined floating-point multiplier on a valid/ready stream.
// S1 unpacks/classifies, S2 multiplies significands, S3 normalises, rounds
// to nearest even, resolves special values and drives the output register.
// A single global stall freezes every stage while the output is held.
// Optional: define FLOAT_MUL_STATUS_EN to add out_flags {invalid, overflow,
// underflow, inexact}, registered alongside out_result.
module float_mul_stream
    import float_mul_pkg::*;
#(
    parameter int exp_width  = 8,
    parameter int mant_width = 23,
    parameter int tag_width  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [float_width(exp_width, mant_width)-1:0] in_a,
    input  logic [float_width(exp_width, mant_width)-1:0] in_b,
    input  logic [tag_width-1:0]                          in_tag,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [float_width(exp_width, mant_width)-1:0] out_result,
    output logic [tag_width-1:0]                          out_tag
`ifdef FLOAT_MUL_STATUS_EN
    ,
    output logic [NUM_FLAGS-1:0]                          out_flags
`endif
);

    localparam int FW  = float_width(exp_width, mant_width);
    localparam int EW2 = exp_width + 2;        // signed exponent headroom
    localparam int PW  = 2 * (mant_width + 1); // full significand product
    localparam logic [EW2-1:0]        BIAS_X  = EW2'(bias(exp_width));
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << exp_width) - 1);

    // Stage records are sized by the module parameters, so they are declared here.
    typedef struct packed {
        logic                 valid;
        logic [tag_width-1:0] tag;
        logic                 sign;
        fclass_e              cls_a;
        fclass_e              cls_b;
        logic [EW2-1:0]       exp;    // two's complement ea+eb-bias
        logic [mant_width:0]  mant_a;
        logic [mant_width:0]  mant_b;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        logic [tag_width-1:0] tag;
        logic                 sign;
        fclass_e              cls_a;
        fclass_e              cls_b;
        logic [EW2-1:0]       exp;
        logic [PW-1:0]        prod;
    } s2_t;

    logic                 sign_a, sign_b;
    logic [exp_width-1:0] exp_a, exp_b;
    logic [mant_width:0]  mant_a, mant_b;
    fclass_e              cls_a, cls_b;

    float_classify #(.exp_width(exp_width), .mant_width(mant_width)) u_class_a (
        .op(in_a), .sign(sign_a), .biased_exp(exp_a), .mant(mant_a), .cls(cls_a)
    );
    float_classify #(.exp_width(exp_width), .mant_width(mant_width)) u_class_b (
        .op(in_b), .sign(sign_b), .biased_exp(exp_b), .mant(mant_b), .cls(cls_b)
    );

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic                 advance;
    logic                 out_valid_d, out_valid_q;
    logic [FW-1:0]        out_result_d, out_result_q;
    logic [tag_width-1:0] out_tag_d, out_tag_q;

    // Whole pipeline moves unless a presented result is not being taken.
    assign advance  = ~(out_valid_q & ~out_ready);
    assign in_ready = advance;

    // S1: sign, classes and the rebiased exponent sum of the incoming pair.
    always_comb begin
        s1_d        = '0;
        s1_d.valid  = in_valid;
        s1_d.tag    = in_tag;
        s1_d.sign   = sign_a ^ sign_b;
        s1_d.cls_a  = cls_a;
        s1_d.cls_b  = cls_b;
        s1_d.exp    = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_X;
        s1_d.mant_a = mant_a;
        s1_d.mant_b = mant_b;
    end

    // S2: full-width significand product, everything else passes through.
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.tag   = s1_q.tag;
        s2_d.sign  = s1_q.sign;
        s2_d.cls_a = s1_q.cls_a;
        s2_d.cls_b = s1_q.cls_b;
        s2_d.exp   = s1_q.exp;
        s2_d.prod  = PW'(s1_q.mant_a) * PW'(s1_q.mant_b);
    end

    logic [PW-2:0]         norm;
    logic [mant_width-1:0] frac;
    logic                  guard, sticky, round_up;
    logic [mant_width:0]   frac_r;
    logic signed [EW2-1:0] exp_f;
    logic                  any_nan, any_inf, any_zero;
    logic                  is_invalid, is_ovf, is_unf, is_finite;

    // S3: normalise, round to nearest even, then resolve specials by priority.
    always_comb begin
        // Product lies in [1,4); drop the leading one after aligning it to the top.
        norm     = s2_q.prod[PW-1] ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
        frac     = norm[PW-2 -: mant_width];
        guard    = norm[mant_width];
        sticky   = |norm[mant_width-1:0];
        round_up = guard & (sticky | frac[0]);
        // A carry out of the fraction leaves it all zeros, i.e. 1.0 at the next exponent.
        frac_r   = {1'b0, frac} + {{mant_width{1'b0}}, round_up};
        exp_f    = s2_q.exp + {{(EW2-1){1'b0}}, s2_q.prod[PW-1]}
                            + {{(EW2-1){1'b0}}, frac_r[mant_width]};

        any_nan    = (s2_q.cls_a == FC_NAN)  | (s2_q.cls_b == FC_NAN);
        any_inf    = (s2_q.cls_a == FC_INF)  | (s2_q.cls_b == FC_INF);
        any_zero   = (s2_q.cls_a == FC_ZERO) | (s2_q.cls_b == FC_ZERO);
        is_invalid = any_nan | (any_inf & any_zero);
        is_finite  = ~any_nan & ~any_inf & ~any_zero;
        is_ovf     = is_finite & (exp_f >= EXP_MAX);
        is_unf     = is_finite & ~is_ovf & (exp_f[EW2-1] | (exp_f == '0));

        out_valid_d  = s2_q.valid;
        out_tag_d    = s2_q.tag;
        out_result_d = {s2_q.sign, exp_f[exp_width-1:0], frac_r[mant_width-1:0]};
        if (is_invalid) begin
            out_result_d = {1'b0, {exp_width{1'b1}}, 1'b1, {(mant_width-1){1'b0}}};
        end else if (any_inf | is_ovf) begin
            out_result_d = {s2_q.sign, {exp_width{1'b1}}, {mant_width{1'b0}}};
        end else if (any_zero | is_unf) begin
            out_result_d = {s2_q.sign, {(FW-1){1'b0}}};
        end
    end

    // Pipeline stage registers, all frozen together while stalled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        // NOTE: only valid bits are reset; payload is don't-care until its valid bit is set.
        if (rst) begin
            s1_q.valid <= 1'b0;
            s2_q.valid <= 1'b0;
        end else if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Output register: fully reset, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (advance) begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

`ifdef FLOAT_MUL_STATUS_EN
    logic [NUM_FLAGS-1:0] flags_d, flags_q;

    // Status flags; inexact covers lost bits on the finite path and any range clamp.
    always_comb begin
        flags_d                 = '0;
        flags_d[FLAG_INVALID]   = is_invalid;
        flags_d[FLAG_OVERFLOW]  = is_ovf;
        flags_d[FLAG_UNDERFLOW] = is_unf;
        flags_d[FLAG_INEXACT]   = is_ovf | is_unf | (is_finite & (guard | sticky));
    end

    // Flag register tracks out_result under the same reset and stall rules.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (advance) begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`endif

endmodule
